// File: rtl/picorv_ram_bridge.sv
// Bridges the PicoRV32 native memory interface onto a single-port synchronous RAM
// with one-cycle read latency and optional programmable wait states.
module picorv_ram_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DATA_DEPTH  = 512,
    parameter int          WAIT_STATES = 0,
    localparam int         AW          = $clog2(DATA_DEPTH)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          mem_valid,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic [AW-1:0] ram_address,
    output logic [3:0]    ram_byteena,
    output logic [31:0]   ram_data,
    output logic          ram_wren,
    input  logic [31:0]   ram_q
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Window bounds carry a 33rd bit so a window ending at 4 GiB does not wrap.
    localparam logic [32:0]   WIN_LO   = {1'b0, BASE_ADDR};
    localparam logic [32:0]   WIN_HI   = {1'b0, BASE_ADDR} + (33'(DATA_DEPTH) * 33'd4);
    localparam logic [3:0]    WS_LAST  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [AW-1:0] BASE_IDX = BASE_ADDR[AW+1:2];

    state_t        state_r;
    state_t        state_nx_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_nx_s;
    logic [AW-1:0] idx_r;
    logic [3:0]    wstrb_r;
    logic          mem_ready_r;
    logic [31:0]   mem_rdata_r;
    logic          hit_s;
    logic          accept_s;
    logic          is_write_s;
    logic [AW-1:0] idx_s;

    // Window decode and accept qualification; accept only ever happens in IDLE.
    always_comb begin
        hit_s      = mem_valid && ({1'b0, mem_addr} >= WIN_LO) && ({1'b0, mem_addr} < WIN_HI);
        accept_s   = resetn && (state_r == ST_IDLE) && hit_s;
        is_write_s = (mem_wstrb != 4'b0000);
        idx_s      = mem_addr[AW+1:2] - BASE_IDX;
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (WAIT_STATES > 0) begin
                        state_nx_s = ST_WAIT;
                        cnt_nx_s   = 4'd0;
                    end else if (is_write_s) begin
                        state_nx_s = ST_RESP;
                    end else begin
                        state_nx_s = ST_CAPTURE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == WS_LAST) begin
                    state_nx_s = (wstrb_r != 4'b0000) ? ST_RESP : ST_CAPTURE;
                end else begin
                    cnt_nx_s = cnt_r + 4'd1;
                end
            end
            ST_CAPTURE: state_nx_s = ST_RESP;
            ST_RESP:    state_nx_s = ST_IDLE;
            default:    state_nx_s = ST_IDLE;
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Transaction context latched on accept and held until the next accept.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx_r   <= '0;
            wstrb_r <= 4'b0000;
        end else if (accept_s) begin
            idx_r   <= idx_s;
            wstrb_r <= mem_wstrb;
        end else begin
            idx_r   <= idx_r;
            wstrb_r <= wstrb_r;
        end
    end

    // Registered response: ready pulses while in RESP, read data captured in CAPTURE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_ready_r <= 1'b0;
            mem_rdata_r <= 32'h0000_0000;
        end else begin
            mem_ready_r <= (state_nx_s == ST_RESP);
            mem_rdata_r <= (state_r == ST_CAPTURE) ? ram_q : mem_rdata_r;
        end
    end

    assign mem_ready   = mem_ready_r;
    assign mem_rdata   = mem_rdata_r;
    assign ram_address = (state_r == ST_IDLE) ? idx_s : idx_r;
    assign ram_wren    = accept_s && is_write_s;
    assign ram_byteena = accept_s ? mem_wstrb : 4'b0000;
    assign ram_data    = mem_wdata;

endmodule
